// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execute unit.
//   - main-control ALU opcodes (alu_op)
//   - decoded ALU control codes (alu_ctrl)
//   - R-type funct field values
//   - signed-overflow helper for add/subtract
package alu_exec_unit_pkg;

    typedef enum logic [1:0] {
        ALU_OP_LDST   = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_RTYPE  = 2'b10,
        ALU_OP_RSVD   = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        CTRL_AND = 4'b0000,
        CTRL_OR  = 4'b0001,
        CTRL_ADD = 4'b0010,
        CTRL_SUB = 4'b0110,
        CTRL_SLT = 4'b0111,
        CTRL_NOR = 4'b1100
    } alu_ctrl_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam int unsigned DATA_W = 32;

    // Signed overflow of x + y: operands agree in sign, sum disagrees.
    // For x - y pass ~y's sign (i.e. the sign of the effective addend).
    function automatic logic add_ovf(input logic x_msb, input logic y_msb,
                                     input logic s_msb);
        return (x_msb == y_msb) && (s_msb != x_msb);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Execute-stage bus between control/register-read and the ALU.
//   master: drives alu_op, funct, a, b, branch; observes ALU outputs.
//   slave : the ALU; drives alu_ctrl (combinational) and registered
//           result, zero, overflow, branch_taken, illegal.
interface alu_exec_unit_if;
    import alu_exec_unit_pkg::*;

    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              branch;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              overflow;
    logic              branch_taken;
    logic              illegal;

    modport master (
        output alu_op, funct, a, b, branch,
        input  alu_ctrl, result, zero, overflow, branch_taken, illegal
    );

    modport slave (
        input  alu_op, funct, a, b, branch,
        output alu_ctrl, result, zero, overflow, branch_taken, illegal
    );

endinterface

// File: rtl/alu_exec_unit_alu_ctrl_decoder.sv
// ALU control decoder (purely combinational).
//   alu_op       : main-control opcode
//   funct        : instruction bits [5:0], only meaningful for R-type
//   alu_ctrl     : decoded ALU operation code
//   illegal_next : R-type with an unrecognised funct (falls back to ADD)
module alu_ctrl_decoder
    import alu_exec_unit_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       illegal_next
);

    always_comb begin
        alu_ctrl     = CTRL_ADD;
        illegal_next = 1'b0;
        case (alu_op)
            ALU_OP_LDST:   alu_ctrl = CTRL_ADD;
            ALU_OP_BRANCH: alu_ctrl = CTRL_SUB;
            ALU_OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = CTRL_ADD;
                    FUNCT_SUB: alu_ctrl = CTRL_SUB;
                    FUNCT_AND: alu_ctrl = CTRL_AND;
                    FUNCT_OR:  alu_ctrl = CTRL_OR;
                    FUNCT_SLT: alu_ctrl = CTRL_SLT;
                    FUNCT_NOR: alu_ctrl = CTRL_NOR;
                    default: begin
                        alu_ctrl     = CTRL_ADD;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            // Reserved opcode behaves like load/store address add.
            default:       alu_ctrl = CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: control decode, 32-bit datapath, one output register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of alu_exec_unit_if
//              alu_ctrl is combinational from alu_op/funct;
//              result/zero/overflow/branch_taken/illegal are registered,
//              one cycle after the inputs that produced them.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_exec_unit_if.slave bus
);

    logic [3:0]        alu_ctrl;
    logic              illegal_d;
    logic [DATA_W-1:0] sum, diff;
    logic              ovf_add, ovf_sub, slt;

    logic [DATA_W-1:0] result_d, result_q;
    logic              zero_d, zero_q;
    logic              overflow_d, overflow_q;
    logic              branch_taken_d, branch_taken_q;
    logic              illegal_q;

    alu_ctrl_decoder u_dec (
        .alu_op       (bus.alu_op),
        .funct        (bus.funct),
        .alu_ctrl     (alu_ctrl),
        .illegal_next (illegal_d)
    );

    always_comb begin
        sum     = bus.a + bus.b;
        diff    = bus.a - bus.b;
        ovf_add = add_ovf(bus.a[DATA_W-1], bus.b[DATA_W-1], sum[DATA_W-1]);
        ovf_sub = add_ovf(bus.a[DATA_W-1], ~bus.b[DATA_W-1], diff[DATA_W-1]);
        // Sign of a-b is wrong exactly when the subtraction overflowed.
        slt     = diff[DATA_W-1] ^ ovf_sub;

        result_d   = sum;
        overflow_d = 1'b0;
        case (alu_ctrl)
            CTRL_AND: result_d = bus.a & bus.b;
            CTRL_OR:  result_d = bus.a | bus.b;
            CTRL_ADD: begin
                result_d   = sum;
                overflow_d = ovf_add;
            end
            CTRL_SUB: begin
                result_d   = diff;
                overflow_d = ovf_sub;
            end
            CTRL_SLT: result_d = {{(DATA_W-1){1'b0}}, slt};
            CTRL_NOR: result_d = ~(bus.a | bus.b);
            default: begin
                result_d   = sum;
                overflow_d = ovf_add;
            end
        endcase

        zero_d         = (result_d == '0);
        branch_taken_d = bus.branch & zero_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q       <= '0;
            zero_q         <= 1'b0;
            overflow_q     <= 1'b0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            result_q       <= result_d;
            zero_q         <= zero_d;
            overflow_q     <= overflow_d;
            branch_taken_q <= branch_taken_d;
            illegal_q      <= illegal_d;
        end
    end

    assign bus.alu_ctrl     = alu_ctrl;
    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.overflow     = overflow_q;
    assign bus.branch_taken = branch_taken_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic br);
        bus.alu_op = op;
        bus.funct  = f;
        bus.a      = av;
        bus.b      = bv;
        bus.branch = br;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] res,
                            input logic z, input logic ov,
                            input logic bt, input logic il);
        chk({tag, ".result"},       bus.result,       res);
        chk({tag, ".zero"},         {31'b0, bus.zero},         {31'b0, z});
        chk({tag, ".overflow"},     {31'b0, bus.overflow},     {31'b0, ov});
        chk({tag, ".branch_taken"}, {31'b0, bus.branch_taken}, {31'b0, bt});
        chk({tag, ".illegal"},      {31'b0, bus.illegal},      {31'b0, il});
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        drive(2'b00, 6'd0, 32'd5, 32'd7, 1'b0);
        #1;
        chk_regs("reset_async", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ctrl_in_reset", {28'b0, bus.alu_ctrl}, 32'h2);
        tick();
        chk_regs("reset_held", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // load/store add
        chk("ldst.ctrl", {28'b0, bus.alu_ctrl}, 32'h2);
        tick();
        chk_regs("ldst", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);

        // branch equal, taken and not taken
        drive(2'b01, 6'd0, 32'h1234, 32'h1234, 1'b1);
        #1 chk("beq.ctrl", {28'b0, bus.alu_ctrl}, 32'h6);
        tick();
        chk_regs("beq_taken", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(2'b01, 6'd0, 32'h1234, 32'h1234, 1'b0);
        tick();
        chk_regs("beq_nobr", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(2'b01, 6'd0, 32'd5, 32'd3, 1'b1);
        tick();
        chk_regs("beq_ne", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // SLT including overflowing difference
        drive(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h1, 1'b0);
        #1 chk("slt.ctrl", {28'b0, bus.alu_ctrl}, 32'h7);
        tick();
        chk_regs("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(2'b10, 6'b101010, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        tick();
        chk_regs("slt_ovf", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(2'b10, 6'b101010, 32'h1, 32'hFFFF_FFFF, 1'b1);
        tick();
        chk_regs("slt_false", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

        // ADD/SUB overflow
        drive(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        tick();
        chk_regs("add_ovf", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(2'b10, 6'b100010, 32'h0, 32'h8000_0000, 1'b0);
        #1 chk("sub.ctrl", {28'b0, bus.alu_ctrl}, 32'h6);
        tick();
        chk_regs("sub_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(2'b10, 6'b100010, 32'd10, 32'd3, 1'b0);
        tick();
        chk_regs("sub_plain", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        // logic ops
        drive(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b0);
        #1 chk("and.ctrl", {28'b0, bus.alu_ctrl}, 32'h0);
        tick();
        chk_regs("and", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b0);
        #1 chk("or.ctrl", {28'b0, bus.alu_ctrl}, 32'h1);
        tick();
        chk_regs("or", 32'hFFFF_F0F0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b0);
        #1 chk("nor.ctrl", {28'b0, bus.alu_ctrl}, 32'hC);
        tick();
        chk_regs("nor", 32'h0000_0F0F, 1'b0, 1'b0, 1'b0, 1'b0);

        // unknown funct falls back to ADD and flags illegal
        drive(2'b10, 6'b111111, 32'd3, 32'd4, 1'b0);
        #1 chk("illegal.ctrl", {28'b0, bus.alu_ctrl}, 32'h2);
        tick();
        chk_regs("illegal", 32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(2'b10, 6'b100000, 32'd1, 32'd2, 1'b0);
        tick();
        chk_regs("illegal_clr", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // reserved opcode is an ADD, never illegal
        drive(2'b11, 6'b111111, 32'h8000_0000, 32'h8000_0000, 1'b1);
        #1 chk("rsvd.ctrl", {28'b0, bus.alu_ctrl}, 32'h2);
        tick();
        chk_regs("rsvd", 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);

        // reset mid-operation with nonzero result
        drive(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h1, 1'b0);
        tick();
        chk_regs("pre_rst", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_regs("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_regs("mid_rst_edge", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 6'd0, 32'd1, 32'd1, 1'b0);
        tick();
        chk_regs("post_rst", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
- REQ-001: Reset is asynchronous and active-high; one clock, all state on its rising edge.
- REQ-002: clk  input  1  system clock.
- REQ-003: rst  input  1  reset.
- REQ-004: alu_op  input  2  main-control ALU opcode: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- REQ-005: funct  input  6  instruction bits [5:0].
- REQ-006: a  input  32  operand A (register read data 1).
- REQ-007: b  input  32  operand B (register read data 2 or sign-extended immediate).
- REQ-008: branch  input  1  branch flag from main control.
- REQ-009: alu_ctrl  output  4  decoded ALU control code (combinational).
- REQ-010: result  output  32  registered ALU result.
- REQ-011: zero  output  1  registered flag, 1 when result == 0.
- REQ-012: overflow  output  1  registered signed-overflow flag for ADD/SUB.
- REQ-013: branch_taken  output  1  registered branch AND zero.
- REQ-014: illegal  output  1  registered flag, unknown funct with alu_op=10.

Function
- REQ-015: alu_ctrl codes SHALL be AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
- REQ-016: alu_op=00 SHALL select ADD; alu_op=01 SHALL select SUB; alu_op=11 SHALL select ADD.
- REQ-017: alu_op=10 SHALL decode funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR.
- REQ-018: alu_op=10 with any other funct SHALL select ADD and set illegal at the next edge.
- REQ-019: alu_ctrl SHALL be purely combinational from alu_op and funct (zero latency).
- REQ-020: ADD/SUB SHALL be 32-bit two's complement, wrapping modulo 2^32, no carry output.
- REQ-021: SLT SHALL output 32'h1 when signed a < signed b, else 0; comparison correct even when a-b overflows.
- REQ-022: NOR SHALL output ~(a|b); AND/OR bitwise.
- REQ-023: overflow SHALL be 1 only for ADD/SUB when operand signs make the signed result wrong; 0 for all other ops.
- REQ-024: result, zero, overflow, illegal SHALL update every rising edge from current inputs (latency 1 cycle, no enable, no handshake).
- REQ-025: branch_taken SHALL be registered (branch & (next result == 0)), aligned with zero in the same cycle.
- REQ-026: zero SHALL be evaluated on the full 32-bit result, for every op including SLT.

Reset
- REQ-027: While rst=1 result=0, zero=0, overflow=0, branch_taken=0, illegal=0, asynchronously.
- REQ-028: First edge after rst deasserts SHALL capture the then-current inputs normally; reset mid-operation discards the pending result.
- REQ-029: alu_ctrl SHALL not depend on rst.

Structure
- REQ-030: A shared package SHALL hold ALU-op codes, alu_ctrl codes and funct constants.
- REQ-031: Decoder SHALL be one sub-module, alu_ctrl_decoder (alu_op, funct -> alu_ctrl, illegal_next); datapath and registers in the top.

Verification
- REQ-032: alu_op=00, a=5, b=7 -> alu_ctrl=0010, next edge result=12, zero=0.
- REQ-033: alu_op=01, branch=1, a=b=32'h1234 -> result=0, zero=1, branch_taken=1; same with branch=0 -> branch_taken=0.
- REQ-034: alu_op=10, funct=101010, a=32'hFFFFFFFF, b=1 -> result=1; a=32'h80000000, b=32'h7FFFFFFF -> result=1.
- REQ-035: alu_op=10 ADD a=b=32'h7FFFFFFF -> result=32'hFFFFFFFE, overflow=1; SUB 0-0x80000000 -> overflow=1.
- REQ-036: alu_op=10, funct=100111, a=32'hF0F0F0F0, b=32'h0F0F0000 -> result=32'h00000F0F; funct=111111 -> ADD result, illegal=1.
- REQ-037: Assert rst between edges with result nonzero -> all registered outputs 0 immediately, before next clk edge.
